// File: rtl/bidir_bus_ctrl.sv
// Bidirectional pad bus controller.
// Round-robin arbitration among NREQ local writers, hand-off to an external
// driver, a fixed turnaround gap between owners, and contention detection
// with a saturating counter. All state is registered on the rising edge of clk.
module bidir_bus_ctrl #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    parameter int TURN  = 2,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wr_data,
    input  logic                  ext_drive,
    inout  wire  [WIDTH-1:0]      pad,
    output logic [NREQ-1:0]       grant,
    output logic                  oe,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  contention,
    output logic [CNT_W-1:0]      cont_cnt
);

    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TCNT_W = (TURN > 1) ? $clog2(TURN) : 1;

    // The turnaround counter is loaded with TURN-1 and the state is left when
    // it reads zero, so the TURN state lasts exactly TURN cycles.
    localparam logic [TCNT_W-1:0] TURN_LAST = TCNT_W'(TURN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [IDX_W-1:0]  PTR_RST   = IDX_W'(NREQ - 1);
    localparam logic [IDX_W:0]    NREQ_EXT  = (IDX_W + 1)'(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_TURN,
        ST_EXT
    } state_t;

    state_t              state_q, state_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic                oe_q, oe_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;        // index of last granted requester
    logic [TCNT_W-1:0]   turn_cnt_q, turn_cnt_d;
    logic [WIDTH-1:0]    rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                contention_q, contention_d;
    logic [CNT_W-1:0]    cont_cnt_q, cont_cnt_d;

    // Per-requester write data slices, selected by the granted index.
    logic [WIDTH-1:0]    slice [NREQ];
    logic [WIDTH-1:0]    drive_data;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign slice[gi] = wr_data[gi*WIDTH +: WIDTH];
    end

    assign drive_data = slice[ptr_q];

    // The only local driver of the pad; released whenever oe is low.
    assign pad = oe_q ? drive_data : {WIDTH{1'bz}};

    // Round-robin winner search.
    logic [IDX_W:0]      start_idx;
    logic [2*NREQ-1:0]   req_dbl;
    logic [NREQ-1:0]     req_rot;
    logic [IDX_W:0]      win_off;
    logic [IDX_W:0]      win_sum;
    logic [IDX_W-1:0]    win_idx;
    logic [NREQ-1:0]     win_onehot;
    logic                any_req;
    logic                req_held;

    // Rotate the request vector so the search begins one past the last owner,
    // pick the lowest set bit, then map the offset back to a real index.
    always_comb begin
        start_idx = {1'b0, ptr_q} + (IDX_W + 1)'(1);
        if (start_idx >= NREQ_EXT) begin
            start_idx = '0;
        end
        req_dbl = {req, req};
        req_rot = NREQ'(req_dbl >> start_idx);
        win_off = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                win_off = (IDX_W + 1)'(j);
            end
        end
        win_sum = start_idx + win_off;
        if (win_sum >= NREQ_EXT) begin
            win_sum = win_sum - NREQ_EXT;
        end
        win_idx    = IDX_W'(win_sum);
        win_onehot = NREQ'(1) << win_idx;
        any_req    = |req;
        req_held   = |(req & grant_q);
    end

    // Next-state and registered-output logic for the ownership FSM.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        oe_d       = oe_q;
        ptr_d      = ptr_q;
        turn_cnt_d = turn_cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // External party has priority over local requesters.
                if (ext_drive) begin
                    state_d    = ST_EXT;
                    rd_data_d  = pad;
                    rd_valid_d = 1'b1;
                end else if (any_req) begin
                    state_d = ST_DRIVE;
                    grant_d = win_onehot;
                    oe_d    = 1'b1;
                    ptr_d   = win_idx;
                end
            end
            ST_DRIVE: begin
                // Owner keeps the bus while it holds req and nobody else
                // claims the pad; other requesters are ignored here.
                if (!req_held || ext_drive) begin
                    state_d    = ST_TURN;
                    grant_d    = '0;
                    oe_d       = 1'b0;
                    turn_cnt_d = TURN_LAST;
                end
            end
            ST_TURN: begin
                // Dead time on the pad; all requests wait until IDLE.
                if (turn_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    turn_cnt_d = turn_cnt_q - TCNT_W'(1);
                end
            end
            ST_EXT: begin
                if (ext_drive) begin
                    rd_data_d  = pad;
                    rd_valid_d = 1'b1;
                end else begin
                    state_d    = ST_TURN;
                    turn_cnt_d = TURN_LAST;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                oe_d    = 1'b0;
            end
        endcase
    end

    // Contention: we drive while the external side claims the pad, or the
    // resolved pad disagrees with what we drive. Case inequality makes any
    // x/z bit count as a disagreement in simulation.
    logic cont_now;

    always_comb begin
        cont_now     = oe_q && (ext_drive || (pad !== drive_data));
        contention_d = cont_now;
        cont_cnt_d   = cont_cnt_q;
        if (cont_now && (cont_cnt_q != CNT_MAX)) begin
            cont_cnt_d = cont_cnt_q + CNT_W'(1);
        end
    end

    // State register; reset releases the pad immediately with no turnaround.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            oe_q         <= 1'b0;
            ptr_q        <= PTR_RST;
            turn_cnt_q   <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            contention_q <= 1'b0;
            cont_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            oe_q         <= oe_d;
            ptr_q        <= ptr_d;
            turn_cnt_q   <= turn_cnt_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            contention_q <= contention_d;
            cont_cnt_q   <= cont_cnt_d;
        end
    end

    assign grant      = grant_q;
    assign oe         = oe_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign contention = contention_q;
    assign cont_cnt   = cont_cnt_q;

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Scoreboard bench for bidir_bus_ctrl: stimulus pushes expected grants,
// read samples and contention counts; a negedge monitor pops and compares.
module tb_bidir_bus_ctrl;

    localparam int WIDTH = 8;
    localparam int NREQ  = 2;
    localparam int TURN  = 2;
    localparam int CNT_W = 2;
    localparam int EXP_W = NREQ + WIDTH;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wr_data;
    logic                  ext_drive;
    logic                  tb_oe;
    logic [WIDTH-1:0]      tb_pad;
    wire  [WIDTH-1:0]      pad;
    logic [NREQ-1:0]       grant;
    logic                  oe;
    logic [WIDTH-1:0]      rd_data;
    logic                  rd_valid;
    logic                  contention;
    logic [CNT_W-1:0]      cont_cnt;

    // External driver model on the shared pad.
    assign pad = tb_oe ? tb_pad : {WIDTH{1'bz}};

    bidir_bus_ctrl #(
        .WIDTH(WIDTH),
        .NREQ (NREQ),
        .TURN (TURN),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .wr_data   (wr_data),
        .ext_drive (ext_drive),
        .pad       (pad),
        .grant     (grant),
        .oe        (oe),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .contention(contention),
        .cont_cnt  (cont_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic rst_edge = 1'b1;

    logic [EXP_W-1:0] q_grant [$];
    logic [WIDTH-1:0] q_rd    [$];
    logic [CNT_W-1:0] q_cont  [$];

    task automatic chk(input logic ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_oe(input string name);
        int n;
        n = 0;
        while (!oe && n < 20) begin
            step(1);
            n++;
        end
        chk(oe == 1'b1, name, 32'(oe), 32'd1);
    endtask

    // Edge bookkeeping for the monitor.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst;
    end

    // Monitor: pops an expectation whenever the DUT presents an event.
    logic             oe_prev  = 1'b0;
    int               fall_cyc = -100;
    logic [EXP_W-1:0] exp_g;
    logic [WIDTH-1:0] exp_r;
    logic [CNT_W-1:0] exp_c;

    always @(negedge clk) begin
        if (rst_edge) begin
            oe_prev  <= 1'b0;
            fall_cyc <= -100;
        end else begin
            if (oe && !oe_prev) begin
                chk((cyc - fall_cyc) >= TURN + 1, "turn_gap",
                    32'(cyc - fall_cyc), 32'(TURN + 1));
                if (q_grant.size() == 0) begin
                    chk(1'b0, "grant_unexpected", 32'({grant, pad}), 32'd0);
                end else begin
                    exp_g = q_grant.pop_front();
                    chk({grant, pad} == exp_g, "grant_pad", 32'({grant, pad}), 32'(exp_g));
                end
            end
            if (!oe && oe_prev) begin
                fall_cyc <= cyc;
            end
            oe_prev <= oe;
            if (rd_valid) begin
                chk(oe == 1'b0, "ext_oe_low", 32'(oe), 32'd0);
                if (q_rd.size() == 0) begin
                    chk(1'b0, "rd_unexpected", 32'(rd_data), 32'd0);
                end else begin
                    exp_r = q_rd.pop_front();
                    chk(rd_data == exp_r, "rd_data", 32'(rd_data), 32'(exp_r));
                end
            end
            if (contention) begin
                if (q_cont.size() == 0) begin
                    chk(1'b0, "cont_unexpected", 32'(cont_cnt), 32'd0);
                end else begin
                    exp_c = q_cont.pop_front();
                    chk(cont_cnt == exp_c, "cont_cnt", 32'(cont_cnt), 32'(exp_c));
                end
            end
        end
    end

    // Hard time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        rst       = 1'b1;
        req       = '0;
        wr_data   = {8'h5A, 8'hA5};
        ext_drive = 1'b0;
        tb_oe     = 1'b0;
        tb_pad    = '0;
        step(3);

        // Reset state.
        chk(oe == 1'b0,         "rst_oe",         32'(oe),         32'd0);
        chk(grant == '0,        "rst_grant",      32'(grant),      32'd0);
        chk(rd_valid == 1'b0,   "rst_rd_valid",   32'(rd_valid),   32'd0);
        chk(rd_data == '0,      "rst_rd_data",    32'(rd_data),    32'd0);
        chk(contention == 1'b0, "rst_contention", 32'(contention), 32'd0);
        chk(cont_cnt == '0,     "rst_cont_cnt",   32'(cont_cnt),   32'd0);
        rst = 1'b0;

        // Single requester: grant in 1 cycle, release 1 cycle after drop.
        q_grant.push_back({2'b01, 8'hA5});
        req = 2'b01;
        step(1);
        chk(oe == 1'b1, "t1_oe_latency", 32'(oe), 32'd1);
        step(2);
        req = 2'b00;
        step(1);
        chk(oe == 1'b0,  "t1_release_oe",    32'(oe),    32'd0);
        chk(grant == '0, "t1_release_grant", 32'(grant), 32'd0);
        step(TURN + 2);

        // Both requesting: owners alternate 0,1,0 with a TURN+1 gap.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        q_grant.push_back({2'b01, 8'hA5});
        q_grant.push_back({2'b10, 8'h5A});
        q_grant.push_back({2'b01, 8'hA5});
        req = 2'b11;
        for (int r = 0; r < 3; r++) begin
            wait_oe("t2_wait_oe");
            step(2);
            req[r % 2] = 1'b0;
            step(1);
            chk(oe == 1'b0, "t2_drop_oe", 32'(oe), 32'd0);
            req = (r < 2) ? 2'b11 : 2'b00;
            if (r < 2) begin
                step(TURN);
                chk(oe == 1'b0, "t2_gap_low", 32'(oe), 32'd0);
                step(1);
                chk(oe == 1'b1, "t2_next_oe", 32'(oe), 32'd1);
            end
        end
        step(TURN + 3);

        // External drive from IDLE: 4 samples, each lagging pad by a cycle.
        for (int k = 0; k < 4; k++) begin
            q_rd.push_back(8'h3C + 8'(k));
        end
        tb_oe     = 1'b1;
        ext_drive = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tb_pad = 8'h3C + 8'(k);
            step(1);
        end
        ext_drive = 1'b0;
        tb_oe     = 1'b0;
        step(1);
        chk(rd_valid == 1'b0, "t3_rd_valid_end", 32'(rd_valid), 32'd0);
        step(TURN + 2);

        // ext_drive while driving FF: contention, release, TURN, then EXT;
        // the still-pending request is served after the next TURN.
        wr_data = {8'h5A, 8'hFF};
        q_grant.push_back({2'b01, 8'hFF});
        req = 2'b01;
        wait_oe("t4_wait_oe");
        step(1);
        ext_drive = 1'b1;
        q_cont.push_back(2'd1);
        q_rd.push_back(8'hC3);
        q_rd.push_back(8'hC3);
        q_grant.push_back({2'b01, 8'hFF});
        step(1);
        chk(oe == 1'b0,  "t4_release_oe",    32'(oe),    32'd0);
        chk(grant == '0, "t4_release_grant", 32'(grant), 32'd0);
        tb_pad = 8'hC3;
        tb_oe  = 1'b1;
        step(4);
        ext_drive = 1'b0;
        tb_oe     = 1'b0;
        wait_oe("t4_served_oe");
        req = 2'b00;
        step(TURN + 3);

        // Five contention cycles saturate a 2-bit counter at 3.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int e = 0; e < 5; e++) begin
            q_grant.push_back({2'b01, 8'hFF});
            req = 2'b01;
            wait_oe("t5_wait_oe");
            q_cont.push_back((e < 2) ? CNT_W'(e + 1) : CNT_W'(3));
            ext_drive = 1'b1;
            step(1);
            ext_drive = 1'b0;
        end
        req = 2'b00;
        step(TURN + 3);
        chk(cont_cnt == 2'd3, "t5_saturated", 32'(cont_cnt), 32'd3);

        // Reset mid-DRIVE: immediate release, pointer back to requester 0.
        q_grant.push_back({2'b10, 8'h5A});
        req = 2'b10;
        wait_oe("t6_wait_oe");
        step(1);
        rst = 1'b1;
        step(1);
        chk(oe == 1'b0,  "t6_rst_oe",       32'(oe),       32'd0);
        chk(grant == '0, "t6_rst_grant",    32'(grant),    32'd0);
        chk(cont_cnt == '0, "t6_rst_cnt",   32'(cont_cnt), 32'd0);
        rst = 1'b0;
        req = 2'b11;
        q_grant.push_back({2'b01, 8'hFF});
        step(1);
        chk(oe == 1'b1,     "t6_no_turnaround", 32'(oe),    32'd1);
        chk(grant == 2'b01, "t6_req0_wins",     32'(grant), 32'd1);
        req = 2'b00;
        step(TURN + 3);

        // Every expected event must have been observed.
        chk(q_grant.size() == 0, "grant_queue_drained", 32'(q_grant.size()), 32'd0);
        chk(q_rd.size() == 0,    "rd_queue_drained",    32'(q_rd.size()),    32'd0);
        chk(q_cont.size() == 0,  "cont_queue_drained",  32'(q_cont.size()),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
